// File: rtl/da_stream_pkg.sv
// Shared helpers for the narrow-to-wide stream packer: slot placement and
// count-field width.
package da_stream_pkg;

  // Width of a sub-word count that must represent 0..ratio inclusive.
  function automatic int count_width(input int ratio);
    return $clog2(ratio) + 1;
  endfunction

  // Bit offset of slot idx inside the packed word. With msb_first the first
  // sub-word received occupies the top slice; otherwise the bottom slice.
  function automatic int slot_lsb(input int idx, input int in_width,
                                  input int ratio, input bit msb_first);
    if (msb_first) begin
      return (ratio - 1 - idx) * in_width;
    end
    return idx * in_width;
  endfunction

endpackage

// File: rtl/fifo_word_packer.sv
// Packs ratio narrow sub-words into one wide word for the async FIFO write
// port. A flush request emits a zero-padded partial word with its valid
// sub-word count. Output register follows valid/ready discipline.
module fifo_word_packer
  import da_stream_pkg::*;
#(
  parameter int in_width  = 8,
  parameter int ratio     = 4,
  parameter bit msb_first = 1'b1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [in_width-1:0]               in_data,
  input  logic                              in_enable,
  output logic                              in_ready,
  input  logic                              flush,
  output logic [in_width*ratio-1:0]         out_data,
  output logic                              out_enable,
  input  logic                              out_ready,
  output logic [count_width(ratio)-1:0]     out_count,
  output logic [15:0]                       words_out
);

  localparam int out_width = in_width * ratio;
  localparam int cnt_w     = count_width(ratio);
  localparam int idx_w     = $clog2(ratio);

  logic [out_width-1:0] acc_q, acc_d;
  logic [idx_w-1:0]     idx_q, idx_d;
  logic [out_width-1:0] out_data_q, out_data_d;
  logic                 out_enable_q, out_enable_d;
  logic [cnt_w-1:0]     out_count_q, out_count_d;
  logic [15:0]          words_out_q, words_out_d;
  logic                 flush_pending_q, flush_pending_d;

  logic                 out_free;
  logic                 last_slot;
  logic                 in_ready_c;
  logic                 accept;
  logic                 transfer;
  logic                 flush_eff;
  logic [out_width-1:0] acc_ins;
  logic [cnt_w-1:0]     level;

  // Handshake terms and the accumulator image including this cycle's sub-word.
  always_comb begin
    out_free   = !out_enable_q || out_ready;
    last_slot  = (idx_q == idx_w'(ratio - 1));
    in_ready_c = !flush_pending_q && (!last_slot || out_free);
    accept     = in_enable && in_ready_c;
    transfer   = out_enable_q && out_ready;
    flush_eff  = flush || flush_pending_q;
    level      = cnt_w'(idx_q) + cnt_w'(accept);
    acc_ins    = acc_q;
    for (int s = 0; s < ratio; s++) begin
      if (accept && (idx_q == idx_w'(s))) begin
        acc_ins[slot_lsb(s, in_width, ratio, msb_first) +: in_width] = in_data;
      end
    end
  end

  // Next-state: complete word, flush (drop / emit / defer), or plain append.
  always_comb begin
    acc_d           = acc_q;
    idx_d           = idx_q;
    out_data_d      = out_data_q;
    out_enable_d    = out_enable_q;
    out_count_d     = out_count_q;
    flush_pending_d = flush_pending_q;
    words_out_d     = words_out_q;

    // A transferred word leaves the register unless replaced below.
    if (transfer) begin
      out_enable_d = 1'b0;
      words_out_d  = words_out_q + 16'd1;
    end

    if (accept && last_slot) begin
      // in_ready guarantees out_free here; a coincident flush is consumed.
      out_data_d      = acc_ins;
      out_enable_d    = 1'b1;
      out_count_d     = cnt_w'(ratio);
      acc_d           = '0;
      idx_d           = '0;
      flush_pending_d = 1'b0;
    end else if (flush_eff) begin
      if (level == '0) begin
        // Nothing buffered: the flush has nothing to emit.
        flush_pending_d = 1'b0;
      end else if (out_free) begin
        // Unused slots are already zero because acc is cleared on every emit.
        out_data_d      = acc_ins;
        out_enable_d    = 1'b1;
        out_count_d     = level;
        acc_d           = '0;
        idx_d           = '0;
        flush_pending_d = 1'b0;
      end else begin
        // Output busy: keep the sub-word, block input, retry next cycle.
        acc_d           = acc_ins;
        idx_d           = idx_q + idx_w'(accept);
        flush_pending_d = 1'b1;
      end
    end else if (accept) begin
      acc_d = acc_ins;
      idx_d = idx_q + idx_w'(1);
    end
  end

  // State register with asynchronous reset; partial words are discarded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q           <= '0;
      idx_q           <= '0;
      out_data_q      <= '0;
      out_enable_q    <= 1'b0;
      out_count_q     <= '0;
      words_out_q     <= '0;
      flush_pending_q <= 1'b0;
    end else begin
      acc_q           <= acc_d;
      idx_q           <= idx_d;
      out_data_q      <= out_data_d;
      out_enable_q    <= out_enable_d;
      out_count_q     <= out_count_d;
      words_out_q     <= words_out_d;
      flush_pending_q <= flush_pending_d;
    end
  end

  assign in_ready   = in_ready_c;
  assign out_data   = out_data_q;
  assign out_enable = out_enable_q;
  assign out_count  = out_count_q;
  assign words_out  = words_out_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench: two packers (msb_first=1 and 0) share one stimulus stream.
// Expected words are queued at issue time; a forked monitor checks each
// output transfer against the queue.
module tb_fifo_word_packer;

  logic        clk;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_enable;
  logic        flush;
  logic        out_ready;
  logic        in_ready_m, in_ready_l;
  logic [31:0] out_data_m, out_data_l;
  logic        out_enable_m, out_enable_l;
  logic [2:0]  out_count_m, out_count_l;
  logic [15:0] words_out_m, words_out_l;

  typedef struct {
    logic [31:0] dm;
    logic [31:0] dl;
    int          cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   failures;

  fifo_word_packer #(.in_width(8), .ratio(4), .msb_first(1'b1)) dut_m (
    .clk(clk), .reset(reset), .in_data(in_data), .in_enable(in_enable),
    .in_ready(in_ready_m), .flush(flush), .out_data(out_data_m),
    .out_enable(out_enable_m), .out_ready(out_ready), .out_count(out_count_m),
    .words_out(words_out_m)
  );

  fifo_word_packer #(.in_width(8), .ratio(4), .msb_first(1'b0)) dut_l (
    .clk(clk), .reset(reset), .in_data(in_data), .in_enable(in_enable),
    .in_ready(in_ready_l), .flush(flush), .out_data(out_data_l),
    .out_enable(out_enable_l), .out_ready(out_ready), .out_count(out_count_l),
    .words_out(words_out_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] dm, input logic [31:0] dl, input int cnt);
    exp_t e;
    e.dm = dm; e.dl = dl; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [7:0] d, input logic fl);
    in_enable = en;
    in_data   = d;
    flush     = fl;
  endtask

  // Send one byte per cycle; every byte here is expected to be accepted.
  task automatic send(input logic [7:0] d);
    drive(1'b1, d, 1'b0);
    chk("send_in_ready", {31'd0, in_ready_m}, 32'd1);
    tick();
  endtask

  // Check every output transfer against the scoreboard.
  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && out_enable_m && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=%h required=none", out_data_m);
        end else begin
          e = exp_q.pop_front();
          chk("lsb_enable", {31'd0, out_enable_l}, 32'd1);
          chk("word_msb", out_data_m, e.dm);
          chk("word_lsb", out_data_l, e.dl);
          chk("count_msb", {29'd0, out_count_m}, e.cnt);
          chk("count_lsb", {29'd0, out_count_l}, e.cnt);
          $display("word msb=%h lsb=%h count=%0d", out_data_m, out_data_l, out_count_m);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    fork
      monitor_loop();
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_enable", {31'd0, out_enable_m}, 32'd0);
    chk("rst_out_data", out_data_m, 32'd0);
    chk("rst_out_count", {29'd0, out_count_m}, 32'd0);
    chk("rst_words_out", {16'd0, words_out_m}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready_m}, 32'd1);
    reset = 1'b0;
    tick();

    // Full word, both orderings, latency of one cycle
    out_ready = 1'b1;
    push(32'h11223344, 32'h44332211, 4);
    send(8'h11); send(8'h22); send(8'h33);
    drive(1'b1, 8'h44, 1'b0);
    chk("pre_last_enable", {31'd0, out_enable_m}, 32'd0);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    chk("latency_enable", {31'd0, out_enable_m}, 32'd1);
    tick();
    chk("words_after_1", {16'd0, words_out_m}, 32'd1);
    chk("words_after_1_lsb", {16'd0, words_out_l}, 32'd1);

    // Partial flush then new word starting at slot 0
    push(32'hAABB0000, 32'h0000BBAA, 2);
    push(32'hCCDDEEFF, 32'hFFEEDDCC, 4);
    send(8'hAA); send(8'hBB);
    drive(1'b0, 8'h00, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    chk("flush_count", {29'd0, out_count_m}, 32'd2);
    send(8'hCC); send(8'hDD); send(8'hEE); send(8'hFF);
    drive(1'b0, 8'h00, 1'b0);
    tick(); tick();
    chk("words_after_3", {16'd0, words_out_m}, 32'd3);

    // Back-pressure: eight bytes with the output stalled
    out_ready = 1'b0;
    push(32'h01020304, 32'h04030201, 4);
    push(32'h05060708, 32'h08070605, 4);
    for (int i = 1; i <= 7; i++) send(8'(i));
    drive(1'b1, 8'h08, 1'b0);
    #1;
    chk("stall_in_ready", {31'd0, in_ready_m}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold_data", out_data_m, 32'h01020304);
      chk("stall_hold_ready", {31'd0, in_ready_m}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", {31'd0, in_ready_m}, 32'd1);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    tick(); tick();
    chk("words_after_5", {16'd0, words_out_m}, 32'd5);

    // Flush with nothing buffered is ignored
    drive(1'b0, 8'h00, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    chk("empty_flush_enable", {31'd0, out_enable_m}, 32'd0);
    tick();
    chk("empty_flush_words", {16'd0, words_out_m}, 32'd5);

    // Flush coinciding with the fourth byte yields one full word
    push(32'h10203040, 32'h40302010, 4);
    send(8'h10); send(8'h20); send(8'h30);
    drive(1'b1, 8'h40, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    chk("flush_full_count", {29'd0, out_count_m}, 32'd4);
    tick();
    chk("flush_full_single", {31'd0, out_enable_m}, 32'd0);
    chk("words_after_6", {16'd0, words_out_m}, 32'd6);

    // Flush at idx=1 while the output is stalled: deferred
    out_ready = 1'b0;
    push(32'h50607080, 32'h80706050, 4);
    push(32'h90000000, 32'h00000090, 1);
    send(8'h50); send(8'h60); send(8'h70); send(8'h80);
    send(8'h90);
    drive(1'b0, 8'h00, 1'b1);
    tick();
    drive(1'b1, 8'hA1, 1'b0);
    #1;
    chk("pending_in_ready_0", {31'd0, in_ready_m}, 32'd0);
    tick();
    chk("pending_in_ready_1", {31'd0, in_ready_m}, 32'd0);
    chk("pending_hold_data", out_data_m, 32'h50607080);
    drive(1'b0, 8'h00, 1'b0);
    out_ready = 1'b1;
    tick();
    chk("pending_count", {29'd0, out_count_m}, 32'd1);
    chk("pending_cleared_ready", {31'd0, in_ready_m}, 32'd1);
    tick(); tick();
    chk("words_after_8", {16'd0, words_out_m}, 32'd8);

    // Asynchronous reset mid-word with a word held at the output
    out_ready = 1'b0;
    send(8'hC1); send(8'hC2); send(8'hC3); send(8'hC4);
    send(8'hB1); send(8'hB2);
    drive(1'b0, 8'h00, 1'b0);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_out_enable", {31'd0, out_enable_m}, 32'd0);
    chk("midrst_words_out", {16'd0, words_out_m}, 32'd0);
    chk("midrst_out_data", out_data_m, 32'd0);
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    tick();
    push(32'hD1D2D3D4, 32'hD4D3D2D1, 4);
    send(8'hD1); send(8'hD2); send(8'hD3); send(8'hD4);
    drive(1'b0, 8'h00, 1'b0);
    tick(); tick();
    chk("words_after_reset", {16'd0, words_out_m}, 32'd1);

    // Drain: every expected word must have appeared
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
